// File: rtl/game_ctrl_pkg.sv
// Shared op codes, FSM state encodings and width helpers for the grid-game turn controller.
package game_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_CLEAR  = 3'd0,
    OP_BOARD  = 3'd1,
    OP_PIECES = 3'd2,
    OP_CURSOR = 3'd3,
    OP_CHECK  = 3'd4,
    OP_PLACE  = 3'd5,
    OP_SCORE  = 3'd6,
    OP_HASMV  = 3'd7
  } op_t;

  typedef enum logic [3:0] {
    S_CLEAR   = 4'd0,
    S_BOARD   = 4'd1,
    S_PIECES  = 4'd2,
    S_IDLE    = 4'd3,
    S_MOVE    = 4'd4,
    S_CURSOR  = 4'd5,
    S_CHECK   = 4'd6,
    S_INVALID = 4'd7,
    S_PLACE   = 4'd8,
    S_SCORE   = 4'd9,
    S_NEXT    = 4'd10,
    S_HASMV   = 4'd11,
    S_OVER    = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  // Never returns 0 so a 1-entry range still gets a 1-bit port.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_op_state(input state_t s);
    case (s)
      S_CLEAR, S_BOARD, S_PIECES, S_CURSOR,
      S_CHECK, S_PLACE, S_SCORE, S_HASMV: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic op_t op_of_state(input state_t s);
    case (s)
      S_BOARD:  return OP_BOARD;
      S_PIECES: return OP_PIECES;
      S_CURSOR: return OP_CURSOR;
      S_CHECK:  return OP_CHECK;
      S_PLACE:  return OP_PLACE;
      S_SCORE:  return OP_SCORE;
      S_HASMV:  return OP_HASMV;
      default:  return OP_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that saturates at zero; expired is high while the count is zero.
module cycle_timer #(
  parameter int WIDTH    = 8,
  parameter int LOAD_VAL = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic count,
  output logic expired
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= WIDTH'(LOAD_VAL);
    end else if (count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign expired = (r_cnt == '0);

endmodule

// File: rtl/game_turn_ctrl.sv
// Turn/sequence controller for grid board games: cursor, current player, phase and datapath op handshake.
// Optional idle-turn forfeit timer is built when GTC_TURN_TIMER_EN is defined.
module game_turn_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int  BOARD_W     = 8,
  parameter int  BOARD_H     = 8,
  parameter int  N_PLAYERS   = 2,
  parameter int  MSG_CYCLES  = 25,
  parameter int  TURN_CYCLES = 1000,
  localparam int XW          = width_of(BOARD_W),
  localparam int YW          = width_of(BOARD_H),
  localparam int PW          = width_of(N_PLAYERS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          btn_enter,
  input  logic          btn_right,
  input  logic          btn_left,
  input  logic          btn_up,
  input  logic          btn_down,
  output logic          op_start,
  output logic [2:0]    op_code,
  output logic [PW-1:0] op_player,
  input  logic          op_done,
  input  logic          move_valid,
  input  logic          has_move,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic [PW-1:0] player,
  output logic          msg_invalid,
  output logic          game_over,
  output logic [3:0]    state_dbg
);

  localparam logic [XW-1:0] X_MAX = XW'(BOARD_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(BOARD_H - 1);
  localparam logic [PW-1:0] P_MAX = PW'(N_PLAYERS - 1);
  localparam int            MW    = width_of(MSG_CYCLES);

  state_t        r_state;
  logic          r_issued;
  logic          r_op_start;
  op_t           r_op_code;
  logic [PW-1:0] r_op_player;
  logic [PW-1:0] r_player;
  logic [PW-1:0] r_cand;
  logic [XW-1:0] r_cursor_x;
  logic [YW-1:0] r_cursor_y;
  dir_t          r_dir;
  logic          r_msg;
  logic          r_game_over;

  logic w_op_ack;
  logic w_msg_expired;

  // Compare-and-zero so non-power-of-two player counts wrap correctly.
  function automatic logic [PW-1:0] next_player(input logic [PW-1:0] p);
    return (p >= P_MAX) ? '0 : p + 1'b1;
  endfunction

  // A done pulse coinciding with our own start pulse belongs to nothing we issued.
  assign w_op_ack = op_done && r_issued && !r_op_start;

  cycle_timer #(
    .WIDTH   (MW),
    .LOAD_VAL(MSG_CYCLES - 1)
  ) u_msg_timer (
    .clk    (clk),
    .resetn (resetn),
    .load   (r_state != S_INVALID),
    .count  (r_state == S_INVALID),
    .expired(w_msg_expired)
  );

`ifdef GTC_TURN_TIMER_EN
  localparam int TW = width_of(TURN_CYCLES);
  logic w_btn_any;
  logic w_turn_expired;

  assign w_btn_any = btn_enter | btn_right | btn_left | btn_up | btn_down;

  cycle_timer #(
    .WIDTH   (TW),
    .LOAD_VAL(TURN_CYCLES - 1)
  ) u_turn_timer (
    .clk    (clk),
    .resetn (resetn),
    .load   ((r_state != S_IDLE) || w_btn_any),
    .count  (r_state == S_IDLE),
    .expired(w_turn_expired)
  );
`else
  logic w_unused_turn;
  assign w_unused_turn = (TURN_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_CLEAR;
      r_issued    <= 1'b0;
      r_op_start  <= 1'b0;
      r_op_code   <= OP_CLEAR;
      r_op_player <= '0;
      r_player    <= '0;
      r_cand      <= '0;
      r_cursor_x  <= '0;
      r_cursor_y  <= '0;
      r_dir       <= DIR_RIGHT;
      r_msg       <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_op_start <= 1'b0;
      if (is_op_state(r_state) && !r_issued) begin
        r_op_start  <= 1'b1;
        r_issued    <= 1'b1;
        r_op_code   <= op_of_state(r_state);
        r_op_player <= (r_state == S_HASMV) ? r_cand : r_player;
      end

      case (r_state)
        S_CLEAR: if (w_op_ack) begin
          r_player   <= '0;
          r_cursor_x <= '0;
          r_cursor_y <= '0;
          r_issued   <= 1'b0;
          r_state    <= S_BOARD;
        end
        S_BOARD: if (w_op_ack) begin
          r_issued <= 1'b0;
          r_state  <= S_PIECES;
        end
        S_PIECES: if (w_op_ack) begin
          r_issued <= 1'b0;
          r_state  <= S_IDLE;
        end
        S_IDLE: begin
          if (btn_enter) begin
            r_state <= S_CHECK;
          end else if (btn_right) begin
            r_dir   <= DIR_RIGHT;
            r_state <= S_MOVE;
          end else if (btn_left) begin
            r_dir   <= DIR_LEFT;
            r_state <= S_MOVE;
          end else if (btn_up) begin
            r_dir   <= DIR_UP;
            r_state <= S_MOVE;
          end else if (btn_down) begin
            r_dir   <= DIR_DOWN;
            r_state <= S_MOVE;
          end
`ifdef GTC_TURN_TIMER_EN
          else if (w_turn_expired) begin
            r_state <= S_NEXT;
          end
`endif
        end
        S_MOVE: begin
          case (r_dir)
            DIR_RIGHT: r_cursor_x <= (r_cursor_x == X_MAX) ? '0 : r_cursor_x + 1'b1;
            DIR_LEFT:  r_cursor_x <= (r_cursor_x == '0) ? X_MAX : r_cursor_x - 1'b1;
            DIR_UP:    r_cursor_y <= (r_cursor_y == '0) ? Y_MAX : r_cursor_y - 1'b1;
            default:   r_cursor_y <= (r_cursor_y == Y_MAX) ? '0 : r_cursor_y + 1'b1;
          endcase
          r_state <= S_CURSOR;
        end
        S_CURSOR: if (w_op_ack) begin
          r_issued <= 1'b0;
          r_state  <= S_IDLE;
        end
        S_CHECK: if (w_op_ack) begin
          r_issued <= 1'b0;
          if (move_valid) begin
            r_state <= S_PLACE;
          end else begin
            r_msg   <= 1'b1;
            r_state <= S_INVALID;
          end
        end
        S_INVALID: if (w_msg_expired) begin
          r_msg   <= 1'b0;
          r_state <= S_CURSOR;
        end
        S_PLACE: if (w_op_ack) begin
          r_issued <= 1'b0;
          r_state  <= S_SCORE;
        end
        S_SCORE: if (w_op_ack) begin
          r_issued <= 1'b0;
          r_state  <= S_NEXT;
        end
        S_NEXT: begin
          r_cand  <= next_player(r_player);
          r_state <= S_HASMV;
        end
        // The current player is the last candidate, so a miss on it means nobody can move.
        S_HASMV: if (w_op_ack) begin
          r_issued <= 1'b0;
          if (has_move) begin
            r_player <= r_cand;
            r_state  <= S_IDLE;
          end else if (r_cand == r_player) begin
            r_game_over <= 1'b1;
            r_state     <= S_OVER;
          end else begin
            r_cand <= next_player(r_cand);
          end
        end
        S_OVER: if (btn_enter) begin
          r_game_over <= 1'b0;
          r_state     <= S_CLEAR;
        end
        default: begin
          r_issued <= 1'b0;
          r_state  <= S_CLEAR;
        end
      endcase
    end
  end

  assign op_start    = r_op_start;
  assign op_code     = r_op_code;
  assign op_player   = r_op_player;
  assign cursor_x    = r_cursor_x;
  assign cursor_y    = r_cursor_y;
  assign player      = r_player;
  assign msg_invalid = r_msg;
  assign game_over   = r_game_over;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Randomized self-checking bench for game_turn_ctrl against a move-level reference model.
module tb_game_turn_ctrl;
  import game_ctrl_pkg::*;

  localparam int N    = 3;
  localparam int W    = 8;
  localparam int H    = 8;
  localparam int MSG  = 4;
  localparam int TURN = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       btn_enter = 1'b0, btn_right = 1'b0, btn_left = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       op_done = 1'b0, move_valid = 1'b0, has_move = 1'b0;
  logic       op_start;
  logic [2:0] op_code;
  logic [1:0] op_player;
  logic [2:0] cursor_x, cursor_y;
  logic [1:0] player;
  logic       msg_invalid, game_over;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  game_turn_ctrl #(
    .BOARD_W(W), .BOARD_H(H), .N_PLAYERS(N), .MSG_CYCLES(MSG), .TURN_CYCLES(TURN)
  ) dut (
    .clk(clk), .resetn(resetn),
    .btn_enter(btn_enter), .btn_right(btn_right), .btn_left(btn_left),
    .btn_up(btn_up), .btn_down(btn_down),
    .op_start(op_start), .op_code(op_code), .op_player(op_player),
    .op_done(op_done), .move_valid(move_valid), .has_move(has_move),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .player(player),
    .msg_invalid(msg_invalid), .game_over(game_over), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Datapath stand-in: logs every op and answers with op_done two cycles after op_start.
  int  log_q[$];
  bit  mv_resp;
  bit  hm_tab[N];
  bit  dp_pending = 1'b0;
  int  dp_player  = 0;

  initial forever begin
    @(negedge clk);
    op_done = 1'b0;
    if (dp_pending) begin
      op_done    = 1'b1;
      move_valid = mv_resp;
      has_move   = (dp_player < N) ? hm_tab[dp_player] : 1'b0;
      dp_pending = 1'b0;
    end
    if (op_start) begin
      log_q.push_back(int'(op_code) * 16 + int'(op_player));
      dp_player  = int'(op_player);
      dp_pending = 1'b1;
    end
  end

  // Reference model: game position in plain integers.
  int m_p = 0, m_x = 0, m_y = 0;
  bit m_over = 1'b0;

  task automatic set_btns(input logic [4:0] mask);
    {btn_down, btn_up, btn_left, btn_right, btn_enter} = mask;
  endtask

  // Run until the controller rests in IDLE or OVER; stray buttons are thrown in while it is busy.
  task automatic settle(output int msg_cnt, output bit ok);
    msg_cnt = 0;
    ok      = 1'b0;
    for (int c = 0; c < 400; c++) begin
      set_btns(5'd0);
      if (state_dbg == S_IDLE || state_dbg == S_OVER) begin
        ok = 1'b1;
        break;
      end
      if (msg_invalid) msg_cnt++;
      if ($urandom_range(0, 3) == 0) set_btns(5'($urandom_range(1, 31)));
      @(negedge clk); #1;
    end
    set_btns(5'd0);
  endtask

  task automatic compare(input string name, input int exp_q[$], input int exp_msg, input int msg_cnt);
    chk({name, " n_ops"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk($sformatf("%s op%0d code", name, i), log_q[i] / 16, exp_q[i] / 16);
      if (exp_q[i] / 16 != int'(OP_CLEAR))
        chk($sformatf("%s op%0d player", name, i), log_q[i] % 16, exp_q[i] % 16);
    end
    chk({name, " player"}, player, m_p);
    chk({name, " cursor_x"}, cursor_x, m_x);
    chk({name, " cursor_y"}, cursor_y, m_y);
    chk({name, " state"}, state_dbg, m_over ? int'(S_OVER) : int'(S_IDLE));
    chk({name, " game_over"}, game_over, m_over);
    chk({name, " msg_cycles"}, msg_cnt, exp_msg);
  endtask

  task automatic do_action(input string name, input logic [4:0] mask);
    int exp_q[$];
    int exp_msg = 0;
    int msg_cnt;
    bit ok;
    bit found = 1'b0;
    if (!m_over) begin
      if (mask[0]) begin
        exp_q.push_back(int'(OP_CHECK) * 16 + m_p);
        if (mv_resp) begin
          exp_q.push_back(int'(OP_PLACE) * 16 + m_p);
          exp_q.push_back(int'(OP_SCORE) * 16 + m_p);
          for (int k = 1; k <= N; k++) begin
            int c = (m_p + k) % N;
            exp_q.push_back(int'(OP_HASMV) * 16 + c);
            if (hm_tab[c]) begin
              m_p   = c;
              found = 1'b1;
              break;
            end
          end
          if (!found) m_over = 1'b1;
        end else begin
          exp_msg = MSG;
          exp_q.push_back(int'(OP_CURSOR) * 16 + m_p);
        end
      end else if (mask != 5'd0) begin
        if (mask[1])      m_x = (m_x + 1) % W;
        else if (mask[2]) m_x = (m_x + W - 1) % W;
        else if (mask[3]) m_y = (m_y + H - 1) % H;
        else              m_y = (m_y + 1) % H;
        exp_q.push_back(int'(OP_CURSOR) * 16 + m_p);
      end
    end else if (mask[0]) begin
      exp_q = '{int'(OP_CLEAR) * 16, int'(OP_BOARD) * 16, int'(OP_PIECES) * 16};
      m_p = 0; m_x = 0; m_y = 0; m_over = 1'b0;
    end
    log_q = {};
    set_btns(mask);
    @(negedge clk); #1;
    settle(msg_cnt, ok);
    chk({name, " settled"}, ok, 1);
    compare(name, exp_q, exp_msg, msg_cnt);
  endtask

  initial begin
    int  exp_q[$];
    int  msg_cnt;
    bit  ok;
    bit  found;

    mv_resp = 1'b0;
    hm_tab  = '{1'b1, 1'b1, 1'b1};
    repeat (3) @(negedge clk);
    #1;
    chk("reset state", state_dbg, S_CLEAR);
    chk("reset op_start", op_start, 0);
    chk("reset op_code", op_code, OP_CLEAR);
    chk("reset msg_invalid", msg_invalid, 0);
    chk("reset game_over", game_over, 0);
    chk("reset cursor", {cursor_x, cursor_y}, 0);
    chk("reset player", player, 0);

    resetn = 1'b1;
    log_q  = {};
    settle(msg_cnt, ok);
    chk("boot settled", ok, 1);
    exp_q = '{int'(OP_CLEAR) * 16, int'(OP_BOARD) * 16, int'(OP_PIECES) * 16};
    compare("boot", exp_q, 0, msg_cnt);

    do_action("left_wrap", 5'b00100);
    do_action("up_wrap", 5'b01000);
    do_action("enter_right_invalid", 5'b00011);
    mv_resp = 1'b1;
    hm_tab  = '{1'b1, 1'b0, 1'b1};
    do_action("valid_skip_p1", 5'b00001);
    hm_tab  = '{1'b0, 1'b0, 1'b0};
    do_action("all_stuck", 5'b00001);
    do_action("over_ignore_right", 5'b00010);
    do_action("over_enter", 5'b00001);

    for (int t = 0; t < 40; t++) begin
      mv_resp = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) hm_tab[i] = ($urandom_range(0, 3) != 0);
      do_action($sformatf("rand%0d", t), 5'($urandom_range(1, 31)));
    end
    if (m_over) do_action("rand_restart", 5'b00001);

    // Abort a PLACE op with reset; its late op_done must not advance the restarted sequence.
    mv_resp = 1'b1;
    hm_tab  = '{1'b1, 1'b1, 1'b1};
    set_btns(5'b00001);
    @(negedge clk); #1;
    set_btns(5'd0);
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (op_start && op_code == OP_PLACE) begin
        found = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    chk("rst place_seen", found, 1);
    resetn = 1'b0;
    @(negedge clk); #1;
    chk("rst state", state_dbg, S_CLEAR);
    chk("rst op_start", op_start, 0);
    log_q  = {};
    resetn = 1'b1;
    m_p = 0; m_x = 0; m_y = 0; m_over = 1'b0;
    settle(msg_cnt, ok);
    chk("rst settled", ok, 1);
    exp_q = '{int'(OP_CLEAR) * 16, int'(OP_BOARD) * 16, int'(OP_PIECES) * 16};
    compare("rst", exp_q, 0, msg_cnt);

`ifdef GTC_TURN_TIMER_EN
    begin
      int idle_cnt = 0;
      log_q = {};
      while (state_dbg == S_IDLE && idle_cnt < 50) begin
        idle_cnt++;
        @(negedge clk); #1;
      end
      chk("turn idle_cycles", idle_cnt, TURN);
      settle(msg_cnt, ok);
      chk("turn settled", ok, 1);
      m_p   = (m_p + 1) % N;
      exp_q = '{int'(OP_HASMV) * 16 + m_p};
      compare("turn", exp_q, 0, msg_cnt);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
